// File: rtl/axi4lite_reg_bank.sv
// axi4lite_reg_bank: parametrised AXI4-Lite slave exposing NUM_REGS memory-mapped registers.
// Registers are read/write (stored here) or read-only (sampled from reg_d), selected by RO_MASK.
// Optional build macro AXIL_REG_WR_PULSE_EN adds reg_wr_pulse, a one-cycle strobe per OKAY write.
module axi4lite_reg_bank #(
   parameter int                      ADDR_WIDTH = 32,
   parameter int                      DATA_WIDTH = 32,
   parameter int                      NUM_REGS   = 16,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
   parameter logic [NUM_REGS-1:0]     RO_MASK    = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic [2:0]                     awprot,
   input  logic                           wvalid,
   output logic                           wready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   output logic                           bvalid,
   input  logic                           bready,
   output logic [1:0]                     bresp,
   input  logic                           arvalid,
   output logic                           arready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic [2:0]                     arprot,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d
`ifdef AXIL_REG_WR_PULSE_EN
   ,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
`endif
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(STRB_W);
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  aw_held, w_held, ar_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]     w_strb_q;
   logic                  w_commit, r_load;

   logic [ADDR_WIDTH-1:0] wr_word, rd_word;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic                  wr_bad, rd_bad, wr_err;
   logic [DATA_WIDTH-1:0] rd_data_nxt;
   logic [1:0]            rd_resp_nxt;

   // Protection bits carry no meaning for this bank.
   logic unused_prot;
   assign unused_prot = ^{awprot, arprot};

   // Address decode: word index relative to BASE_ADDR, low byte-offset bits dropped.
   assign wr_word = (aw_addr_q - BASE_ADDR) >> OFFS;
   assign rd_word = (ar_addr_q - BASE_ADDR) >> OFFS;
   assign wr_idx  = wr_word[IDX_W-1:0];
   assign rd_idx  = rd_word[IDX_W-1:0];
   assign wr_bad  = (aw_addr_q < BASE_ADDR) || (wr_word >= ADDR_WIDTH'(NUM_REGS));
   assign rd_bad  = (ar_addr_q < BASE_ADDR) || (rd_word >= ADDR_WIDTH'(NUM_REGS));
   assign wr_err  = wr_bad || RO_MASK[wr_idx];

   // Expose RW contents; RO slices are forced to zero.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
      assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
   end

   // State registers for both channel FSMs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_nxt;
         r_state <= r_state_nxt;
      end
   end

   // Write FSM: commit once both AW and W are held, then wait for bready.
   always_comb begin
      w_state_nxt = w_state;
      w_commit    = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_held && w_held) begin
               w_commit    = 1'b1;
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Read FSM: load the response one edge after AR capture, then wait for rready.
   always_comb begin
      r_state_nxt = r_state;
      r_load      = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (ar_held) begin
               r_load      = 1'b1;
               r_state_nxt = R_DATA;
            end
         end
         R_DATA: begin
            if (rready) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read data select: stored value, sampled status input, or zero on a bad address.
   always_comb begin
      rd_data_nxt = '0;
      rd_resp_nxt = RESP_OKAY;
      if (rd_bad) begin
         rd_resp_nxt = RESP_SLVERR;
      end else if (RO_MASK[rd_idx]) begin
         rd_data_nxt = reg_d[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         rd_data_nxt = regs[rd_idx];
      end
   end

   // Write channel: independent AW/W capture, response hold until bready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready   <= 1'b0;
         wready    <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
      end else if (w_state == W_IDLE) begin
         if (w_commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (awvalid && awready) begin
               aw_held   <= 1'b1;
               aw_addr_q <= awaddr;
               awready   <= 1'b0;
            end else if (!aw_held) begin
               awready <= 1'b1;
            end
            if (wvalid && wready) begin
               w_held   <= 1'b1;
               w_data_q <= wdata;
               w_strb_q <= wstrb;
               wready   <= 1'b0;
            end else if (!w_held) begin
               wready <= 1'b1;
            end
         end
      end else if (bready) begin
         bvalid  <= 1'b0;
         awready <= 1'b1;
         wready  <= 1'b1;
      end
   end

   // Register storage: byte-masked update on an error-free commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (w_commit && !wr_err) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) regs[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
         end
      end
   end

   // Read channel: capture AR, register rdata/rresp, hold until rready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arready   <= 1'b0;
         ar_held   <= 1'b0;
         ar_addr_q <= '0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         rresp     <= RESP_OKAY;
      end else if (r_state == R_IDLE) begin
         if (r_load) begin
            ar_held <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_data_nxt;
            rresp   <= rd_resp_nxt;
         end else if (arvalid && arready) begin
            ar_held   <= 1'b1;
            ar_addr_q <= araddr;
            arready   <= 1'b0;
         end else begin
            arready <= 1'b1;
         end
      end else if (rready) begin
         rvalid  <= 1'b0;
         arready <= 1'b1;
      end
   end

`ifdef AXIL_REG_WR_PULSE_EN
   // One-cycle strobe for every OKAY commit, including all-zero strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (w_commit && !wr_err) reg_wr_pulse[wr_idx] <= 1'b1;
      end
   end
`endif

endmodule
